// File: rtl/gl_lock_reset_seq.sv
// gl_lock_reset_seq: holds the GLx domain in reset until CCC LOCK has been continuously stable.
// Define GL_LOCK_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise it reads 0.
module gl_lock_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lock_i,
  input  logic             ext_rst_req_i,
  output logic             fabric_rst_n_o,
  output logic             ready_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] lock_lost_cnt_o
);
  localparam int MAXC = STABLE_CYCLES > HOLD_CYCLES ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, RELEASE, RUN} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   run_q;
  logic                   lock_s;
  assign lock_s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], lock_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= state_d == RUN;
    end
  end
  // Every exit toward a lower state clears cnt so each phase counts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      WAIT_LOCK: state_d = lock_s ? QUALIFY : WAIT_LOCK;
      QUALIFY: begin
        state_d = !lock_s ? WAIT_LOCK : (cnt_q == STABLE_LAST) ? RELEASE : QUALIFY;
        cnt_d   = (lock_s && cnt_q != STABLE_LAST) ? cnt_q + 1'b1 : '0;
      end
      RELEASE: begin
        state_d = !lock_s ? WAIT_LOCK : (cnt_q == HOLD_LAST) ? RUN : RELEASE;
        cnt_d   = (lock_s && cnt_q != HOLD_LAST) ? cnt_q + 1'b1 : '0;
      end
      RUN: state_d = !lock_s ? WAIT_LOCK : ext_rst_req_i ? RELEASE : RUN;
      default: state_d = WAIT_LOCK;
    endcase
  end
  assign fabric_rst_n_o = run_q;
  assign ready_o        = run_q;
  assign state_o        = state_q;
`ifdef GL_LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] lost_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lost_q <= '0;
    else if (state_q == RUN && !lock_s && lost_q != '1) lost_q <= lost_q + 1'b1;
  end
  assign lock_lost_cnt_o = lost_q;
`else
  assign lock_lost_cnt_o = '0;
`endif
endmodule
